// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared op codes, FSM state encoding and iterator modes for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// Module      : alu_muldiv_iter
// Description : Shared 2*WIDTH shift register for shift-add multiply and
//               restoring divide, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH + 1);

    logic               r_busy;
    logic               r_mode;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_next;

    // Multiply: multiplier sits in the low half and is consumed LSB first while
    // the partial product (with its carry) shifts down from the high half.
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    // Divide: remainder in the high half, dividend/quotient in the low half.
    assign w_rem      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_rem >= {1'b0, r_b});
    assign w_diff     = w_rem - {1'b0, r_b};
    assign w_div_next = w_ge ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};

    assign w_next = (r_mode == MODE_DIV) ? w_div_next : w_mul_next;

    // Results are the value the register is about to take on the final step.
    assign done   = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign res_lo = w_next[WIDTH-1:0];
    assign res_hi = w_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_mode <= MODE_MUL;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_b    <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_mode <= mode;
            r_cnt  <= '0;
            r_acc  <= {{WIDTH{1'b0}}, a};
            r_b    <= b;
        end else if (r_busy) begin
            r_acc <= w_next;
            if (done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Handshaked unsigned ALU: single-cycle add/sub, iterative
//               mul/div, results held until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic             overflow,
    output logic             div_zero,
    output logic             bad_op
);

    state_t           r_state;
    logic             w_accept;
    logic             w_start;
    logic             w_it_done;
    logic [WIDTH-1:0] w_res_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && ((op == OP_MUL) || ((op == OP_DIV) && (B != '0)));

    // The top bit is carry for add and borrow (A<B) for sub.
    assign w_sum = {1'b0, A} + {1'b0, B};
    assign w_dif = {1'b0, A} - {1'b0, B};

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .mode   ((op == OP_DIV) ? MODE_DIV : MODE_MUL),
        .a      (A),
        .b      (B),
        .done   (w_it_done),
        .res_lo (w_res_lo),
        .res_hi (w_res_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            Y        <= '0;
            R        <= '0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            bad_op   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_ADD: begin
                                {overflow, Y} <= w_sum;
                                R             <= '0;
                                r_state       <= DONE;
                            end
                            OP_SUB: begin
                                {overflow, Y} <= w_dif;
                                R             <= '0;
                                r_state       <= DONE;
                            end
                            OP_MUL: r_state <= MUL;
                            OP_DIV: begin
                                if (B == '0) begin
                                    Y        <= '0;
                                    R        <= '0;
                                    overflow <= 1'b0;
                                    div_zero <= 1'b1;
                                    r_state  <= DONE;
                                end else begin
                                    r_state <= DIV;
                                end
                            end
                            default: begin
                                Y        <= '0;
                                R        <= '0;
                                overflow <= 1'b0;
                                bad_op   <= 1'b1;
                                r_state  <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    if (w_it_done) begin
                        Y        <= w_res_lo;
                        R        <= '0;
                        overflow <= |w_res_hi;
                        r_state  <= DONE;
                    end
                end
                DIV: begin
                    if (w_it_done) begin
                        Y        <= w_res_lo;
                        R        <= w_res_hi;
                        overflow <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        div_zero <= 1'b0;
                        bad_op   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam logic [3:0] C_ADD = 4'b0001;
    localparam logic [3:0] C_SUB = 4'b0010;
    localparam logic [3:0] C_MUL = 4'b0100;
    localparam logic [3:0] C_DIV = 4'b1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, ordy32, of32, dz32, bo32;
    logic [31:0] a32, b32, y32, r32;
    logic [3:0]  op32;
    logic        iv8, ir8, ov8, ordy8, of8, dz8, bo8;
    logic [7:0]  a8, b8, y8, r8;
    logic [3:0]  op8;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
        .op(op32), .out_valid(ov32), .out_ready(ordy32), .Y(y32), .R(r32),
        .overflow(of32), .div_zero(dz32), .bad_op(bo32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .op(op8), .out_valid(ov8), .out_ready(ordy8), .Y(y8), .R(r8),
        .overflow(of8), .div_zero(dz8), .bad_op(bo8)
    );

    // Reference: plain 64-bit arithmetic on masked operands.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, output logic [31:0] y,
                                  output logic [31:0] r, output logic of, output logic dz,
                                  output logic bo, output int lat);
        logic [63:0] mask, x, p;
        mask = (64'd1 << w) - 64'd1;
        y = '0; r = '0; of = 0; dz = 0; bo = 0; lat = 1;
        case (op)
            C_ADD: begin
                x = {32'd0, a} + {32'd0, b};
                y = 32'(x & mask); of = (x > mask);
            end
            C_SUB: begin
                y = 32'((64'(a) - 64'(b)) & mask); of = (a < b);
            end
            C_MUL: begin
                p = 64'(a) * 64'(b);
                y = 32'(p & mask); of = ((p >> w) != 64'd0); lat = w + 1;
            end
            C_DIV: begin
                if (b == 0) dz = 1;
                else begin y = a / b; r = a % b; lat = w + 1; end
            end
            default: bo = 1;
        endcase
    endfunction

    task automatic drive(input bit s, input logic iv, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (s) begin iv8 = iv; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else   begin iv32 = iv; op32 = op; a32 = a; b32 = b; end
    endtask

    task automatic set_ready(input bit s, input logic v);
        if (s) ordy8 = v; else ordy32 = v;
    endtask

    function automatic void peek(input bit s, output logic irdy, output logic ovld,
                                 output logic [31:0] y, output logic [31:0] r,
                                 output logic of, output logic dz, output logic bo);
        if (s) begin irdy = ir8; ovld = ov8; y = {24'd0, y8}; r = {24'd0, r8}; of = of8; dz = dz8; bo = bo8; end
        else   begin irdy = ir32; ovld = ov32; y = y32; r = r32; of = of32; dz = dz32; bo = bo32; end
    endfunction

    // One full transaction: accept, wait for result, optional stall, consume.
    task automatic run_op(input bit s, input logic [3:0] op, input logic [31:0] a_in,
                          input logic [31:0] b_in, input int stall, input int pulse_at);
        logic [31:0] a, b, ey, er, y, r;
        logic eo, ed, eb, irdy, ovld, of, dz, bo;
        int lat, n, w;
        w = s ? 8 : 32;
        a = s ? {24'd0, a_in[7:0]} : a_in;
        b = s ? {24'd0, b_in[7:0]} : b_in;
        model(w, a, b, op, ey, er, eo, ed, eb, lat);
        drive(s, 1'b1, op, a, b);
        peek(s, irdy, ovld, y, r, of, dz, bo);
        n_cmp++;
        if (irdy !== 1'b1) begin n_bad++; $display("FAIL accept_ready w=%0d got %b want 1", w, irdy); end
        @(posedge clk); #1;
        drive(s, 1'b0, 4'($urandom), $urandom, $urandom);
        n = 1;
        peek(s, irdy, ovld, y, r, of, dz, bo);
        while (ovld !== 1'b1 && n < 100) begin
            if (n == pulse_at) drive(s, 1'b1, C_ADD, 32'd1, 32'd1);
            @(posedge clk); #1;
            drive(s, 1'b0, op, a, b);
            n++;
            peek(s, irdy, ovld, y, r, of, dz, bo);
        end
        n_cmp++;
        if (n !== lat) begin n_bad++; $display("FAIL latency w=%0d op=%b got %0d want %0d", w, op, n, lat); end
        n_cmp++;
        if ({y, r, of, dz, bo} !== {ey, er, eo, ed, eb}) begin
            n_bad++;
            $display("FAIL result w=%0d op=%b a=%h b=%h got y=%h r=%h of=%b dz=%b bo=%b want y=%h r=%h of=%b dz=%b bo=%b",
                     w, op, a, b, y, r, of, dz, bo, ey, er, eo, ed, eb);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            peek(s, irdy, ovld, y, r, of, dz, bo);
            n_cmp++;
            if ({irdy, ovld, y, r, of, dz, bo} !== {1'b0, 1'b1, ey, er, eo, ed, eb}) begin
                n_bad++;
                $display("FAIL hold cyc=%0d got rdy=%b vld=%b y=%h r=%h want rdy=0 vld=1 y=%h r=%h", i, irdy, ovld, y, r, ey, er);
            end
        end
        set_ready(s, 1'b1);
        @(posedge clk); #1;
        set_ready(s, 1'b0);
        peek(s, irdy, ovld, y, r, of, dz, bo);
        n_cmp++;
        if ({irdy, ovld, dz, bo, y, r} !== {1'b1, 1'b0, 1'b0, 1'b0, ey, er}) begin
            n_bad++;
            $display("FAIL release got rdy=%b vld=%b dz=%b bo=%b y=%h r=%h want rdy=1 vld=0 dz=0 bo=0 y=%h r=%h",
                     irdy, ovld, dz, bo, y, r, ey, er);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ir32, ov32, y32, r32, of32, dz32, bo32} !== {1'b1, 1'b0, 64'd0, 3'b000}) begin
            n_bad++; $display("FAIL reset32 got rdy=%b vld=%b y=%h r=%h want rdy=1 vld=0 zeros", ir32, ov32, y32, r32);
        end
        n_cmp++;
        if ({ir8, ov8, y8, r8, of8, dz8, bo8} !== {1'b1, 1'b0, 16'd0, 3'b000}) begin
            n_bad++; $display("FAIL reset8 got rdy=%b vld=%b y=%h r=%h want rdy=1 vld=0 zeros", ir8, ov8, y8, r8);
        end
    endtask

    task automatic test_directed();
        run_op(0, C_ADD, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_op(0, C_SUB, 32'd3, 32'd5, 0, 0);
        run_op(0, C_MUL, 32'h0001_0000, 32'h0001_0000, 0, 0);
        run_op(0, C_MUL, 32'd7, 32'd6, 0, 0);
        run_op(0, C_DIV, 32'd100, 32'd7, 0, 0);
        run_op(0, C_DIV, 32'd5, 32'd0, 0, 0);
        run_op(0, 4'b0011, 32'd9, 32'd9, 0, 0);
        run_op(0, C_DIV, 32'hFFFF_FFFF, 32'd1, 0, 0);
    endtask

    task automatic test_ignore_busy();
        run_op(0, C_MUL, 32'd7, 32'd6, 0, 5);
        run_op(0, C_DIV, 32'd1000, 32'd33, 0, 12);
    endtask

    task automatic test_backpressure();
        run_op(0, C_DIV, 32'd100, 32'd7, 10, 0);
        run_op(0, C_DIV, 32'd5, 32'd0, 10, 0);
    endtask

    task automatic test_reset_mid_div();
        drive(0, 1'b1, C_DIV, 32'hDEAD_BEEF, 32'd3);
        @(posedge clk); #1;
        drive(0, 1'b0, C_DIV, 32'hDEAD_BEEF, 32'd3);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ir32, ov32, y32, r32, of32, dz32, bo32} !== {1'b1, 1'b0, 64'd0, 3'b000}) begin
            n_bad++; $display("FAIL async_reset got rdy=%b vld=%b y=%h r=%h want rdy=1 vld=0 zeros", ir32, ov32, y32, r32);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(0, C_ADD, 32'd2, 32'd2, 0, 0);
        run_op(0, C_MUL, 32'd12345, 32'd678, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, ey, er;
        logic [3:0]  op;
        logic eo, ed, eb;
        int lat;
        ordy32 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            op = (i % 2 == 0) ? C_ADD : C_SUB;
            model(32, a, b, op, ey, er, eo, ed, eb, lat);
            drive(0, 1'b1, op, a, b);
            @(posedge clk); #1;
            n_cmp++;
            if ({ov32, ir32, y32, of32} !== {1'b1, 1'b0, ey, eo}) begin
                n_bad++; $display("FAIL b2b i=%0d got vld=%b rdy=%b y=%h of=%b want vld=1 rdy=0 y=%h of=%b",
                                  i, ov32, ir32, y32, of32, ey, eo);
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({ir32, ov32} !== 2'b10) begin
                n_bad++; $display("FAIL b2b_idle i=%0d got rdy=%b vld=%b want rdy=1 vld=0", i, ir32, ov32);
            end
        end
        drive(0, 1'b0, C_ADD, 32'd0, 32'd0);
        ordy32 = 1'b0;
    endtask

    task automatic test_width8();
        run_op(1, C_ADD, 32'hFF, 32'd1, 0, 0);
        run_op(1, C_SUB, 32'd3, 32'd5, 0, 0);
        run_op(1, C_MUL, 32'd16, 32'd16, 0, 0);
        run_op(1, C_MUL, 32'd7, 32'd6, 0, 0);
        run_op(1, C_DIV, 32'd200, 32'd7, 3, 0);
        run_op(1, C_DIV, 32'd5, 32'd0, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] b;
        int k;
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 4);
            op = (k < 4) ? 4'(1 << k) : ((($urandom_range(0, 1)) != 0) ? 4'b0000 : 4'b1111);
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) != 0) b = b >> $urandom_range(0, 28);
            run_op(bit'(i % 3 == 2), op, $urandom, b, $urandom_range(0, 3), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        ordy32 = 1'b0;
        ordy8  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_directed();
        test_ignore_busy();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        test_width8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
